seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DW, default 5, giving divisor and remainder width; dividend and quotient width is 2*DW.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port dividend  input  2*DW  the unsigned dividend, sampled on load.
REQ-005 SHALL have port divisor  input  DW  the unsigned divisor, sampled on load.
REQ-006 SHALL have port load  input  1  the start request, sampled each rising edge.
REQ-007 SHALL have port quotient  output  2*DW  the registered quotient.
REQ-008 SHALL have port remainder  output  DW  the registered remainder.
REQ-009 SHALL have port busy  output  1  high while a division is in progress or completing.
REQ-010 SHALL have port done  output  1  a one-cycle completion pulse.
REQ-011 SHALL have port div_zero  output  1  flags that the divisor was zero; valid with done.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE, all registered.
REQ-013 In IDLE with load=1 at edge E0, SHALL capture dividend and divisor, clear the partial remainder (DW+1 bits) and the iteration counter, and enter CALC.
REQ-014 SHALL ignore load in CALC and DONE: no recapture, no restart, no error.
REQ-015 In CALC, SHALL do one restoring step per edge: shift the next dividend bit (MSB first) into the partial remainder, trial-subtract the divisor, keep the difference and set quotient bit 1 if non-negative, otherwise restore and set 0.
REQ-016 SHALL do exactly 2*DW steps (edges E1..E10 for DW=5), then enter DONE at the edge of the last step.
REQ-017 SHALL update quotient and remainder only on entry to DONE; they SHALL hold the previous result through IDLE and CALC until the next DONE entry.
REQ-018 SHALL assert done for exactly one cycle, the DONE state; DONE SHALL return to IDLE on the next edge (latency load edge to done = 2*DW+1 cycles).
REQ-019 SHALL assert busy in CALC and DONE and deassert it in IDLE; a new load is accepted on the edge that leaves DONE only if the state is IDLE, i.e. the next cycle.
REQ-020 SHALL compute quotient = dividend / divisor and remainder = dividend % divisor for any divisor >= 1, with no truncation.
REQ-021 With divisor = 0, SHALL produce quotient = all ones and remainder = dividend[DW-1:0].
REQ-022 SHALL drive div_zero high with done when the captured divisor was zero, and low otherwise; it holds with the result.

Reset
REQ-023 reset low SHALL immediately force IDLE, quotient=0, remainder=0, busy=0, done=0, div_zero=0 and clear the counter and working registers.
REQ-024 Reset asserted mid-CALC SHALL abort the division; no done is produced for it.
REQ-025 After reset deasserts, the first load SHALL be accepted on the next rising edge.

Configuration
REQ-026 Macro SEQ_DIVIDER_ZERO_SHORTCUT_EN SHALL select zero-divisor handling.
REQ-027 With SEQ_DIVIDER_ZERO_SHORTCUT_EN defined, a zero divisor SHALL skip CALC: IDLE goes to DONE at E0, done in the next cycle, with the REQ-021 result and div_zero=1.
REQ-028 Without SEQ_DIVIDER_ZERO_SHORTCUT_EN, a zero divisor SHALL run the full 2*DW steps and give the same REQ-021 result; div_zero SHALL still be 1.

Verification
REQ-029 SHALL test dividend=1000, divisor=31, load one cycle -> done 11 cycles later; quotient=32, remainder=8, div_zero=0.
REQ-030 SHALL test dividend=1023, divisor=1 -> quotient=1023, remainder=0; dividend=7, divisor=9 -> quotient=0, remainder=7.
REQ-031 SHALL test dividend=500, divisor=0 -> quotient=1023, remainder=20, div_zero=1; done 1 cycle after load with the macro, 11 cycles without it.
REQ-032 SHALL test load=1 held for 15 cycles with dividend changing each cycle -> only the first operands are used, one done pulse, then a second division starts in the cycle after DONE.
REQ-033 SHALL test reset low at cycle 5 of a 1000/31 division -> all outputs 0 at once, no done; a later 100/7 gives quotient=14, remainder=2.
REQ-034 SHALL test 100 random operand pairs, each checked at done against the / and % results.

Source files
------------

// File: rtl/seq_divider.sv
// Restoring sequential divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per clock.
// Define SEQ_DIVIDER_ZERO_SHORTCUT_EN to finish a zero-divisor request without iterating.
module seq_divider #(
   parameter int DW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2*DW-1:0]   dividend,
   input  logic [DW-1:0]     divisor,
   input  logic              load,
   output logic [2*DW-1:0]   quotient,
   output logic [DW-1:0]     remainder,
   output logic              busy,
   output logic              done,
   output logic              div_zero
);

   // state | meaning
   // IDLE  | waiting for load; result registers hold the last answer
   // CALC  | one restoring step per clock, 2*DW steps total
   // DONE  | result valid, done pulse, back to IDLE next clock
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int QW = 2 * DW;
   localparam int CW = $clog2(QW);
   localparam logic [CW-1:0] LAST = CW'(QW - 1);

   state_t          state;
   state_t          state_nxt;
   logic [QW-1:0]   dvd_r;
   logic [DW-1:0]   dvs_r;
   logic [DW-1:0]   prem;
   logic [CW-1:0]   cnt;

   logic [DW:0]     rem_shift;
   logic [DW-1:0]   diff;
   logic [DW-1:0]   prem_nxt;
   logic            q_bit;
   logic            start;
   logic            last_step;
   logic            zero_skip;

   // Quotient bits shift into the low end of dvd_r as dividend bits leave the top.
   assign rem_shift = {prem, dvd_r[QW-1]};
   assign q_bit     = (rem_shift >= {1'b0, dvs_r});
   assign diff      = rem_shift[DW-1:0] - dvs_r;
   assign prem_nxt  = q_bit ? diff : rem_shift[DW-1:0];
   assign start     = (state == IDLE) && load;
   assign last_step = (state == CALC) && (cnt == LAST);

`ifdef SEQ_DIVIDER_ZERO_SHORTCUT_EN
   assign zero_skip = start && (divisor == '0);
`else
   assign zero_skip = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = zero_skip ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         CALC: busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dvd_r     <= '0;
         dvs_r     <= '0;
         prem      <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         if (start) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            prem  <= '0;
            cnt   <= '0;
         end else if (state == CALC) begin
            dvd_r <= {dvd_r[QW-2:0], q_bit};
            prem  <= prem_nxt;
            cnt   <= cnt + CW'(1);
         end

         // Results change only when DONE is entered.
         if (zero_skip) begin
            quotient  <= '1;
            remainder <= dividend[DW-1:0];
            div_zero  <= 1'b1;
         end else if (last_step) begin
            quotient  <= {dvd_r[QW-2:0], q_bit};
            remainder <= prem_nxt;
            div_zero  <= (dvs_r == '0);
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (DW=5); honours SEQ_DIVIDER_ZERO_SHORTCUT_EN for zero-divisor latency.
module tb_seq_divider;

   localparam int DW = 5;
`ifdef SEQ_DIVIDER_ZERO_SHORTCUT_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 11;
`endif

   typedef struct {
      logic [9:0] q;
      logic [4:0] r;
      logic       dz;
      int         lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  dividend;
   logic [4:0]  divisor;
   logic        load;
   logic [9:0]  quotient;
   logic [4:0]  remainder;
   logic        busy;
   logic        done;
   logic        div_zero;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [9:0]  prev_q = '0;
   logic [4:0]  prev_r = '0;

   seq_divider #(.DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .dividend  (dividend),
      .divisor   (divisor),
      .load      (load),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [9:0] a, input logic [4:0] b);
      exp_t       e;
      logic [9:0] rr;
      if (b == 5'd0) begin
         e.q   = '1;
         e.r   = a[4:0];
         e.dz  = 1'b1;
         e.lat = ZLAT;
      end else begin
         e.q   = a / {5'd0, b};
         rr    = a % {5'd0, b};
         e.r   = rr[4:0];
         e.dz  = 1'b0;
         e.lat = 11;
      end
      return e;
   endfunction

   task automatic test_reset();
      reset    = 1'b0;
      load     = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (quotient !== 10'd0 || remainder !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got q=%0d r=%0d busy=%b done=%b dz=%b, expected all zero",
                  quotient, remainder, busy, done, div_zero);
      end
      reset = 1'b1;
   endtask

   task automatic do_div(input logic [9:0] a, input logic [4:0] b, input string name);
      exp_t e;
      int   cyc;
      sb.push_back(model(a, b));
      @(negedge clk);
      dividend = a;
      divisor  = b;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      cyc  = 1;
      while (done !== 1'b1 && cyc < 40) begin
         if (cyc == 1) begin
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL %s busy_calc: got %b expected 1", name, busy);
            end
         end
         if (cyc == 3) begin
            n_tests++;
            if (quotient !== prev_q || remainder !== prev_r) begin
               n_fail++;
               $display("FAIL %s hold_result: got q=%0d r=%0d expected q=%0d r=%0d",
                        name, quotient, remainder, prev_q, prev_r);
            end
         end
         @(negedge clk);
         cyc++;
      end
      e = sb.pop_front();
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s timeout: no done after %0d cycles, expected at %0d", name, cyc, e.lat);
      end else begin
         if (cyc != e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
         end
         n_tests++;
         if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s result: got q=%0d r=%0d dz=%b busy=%b expected q=%0d r=%0d dz=%b busy=1",
                     name, quotient, remainder, div_zero, busy, e.q, e.r, e.dz);
         end
         prev_q = e.q;
         prev_r = e.r;
         @(negedge clk);
         n_tests++;
         if (done !== 1'b0 || busy !== 1'b0 || quotient !== e.q || div_zero !== e.dz) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b busy=%b q=%0d dz=%b expected 0 0 %0d %b",
                     name, done, busy, quotient, div_zero, e.q, e.dz);
         end
      end
   endtask

   task automatic test_basic();
      do_div(10'd1000, 5'd31, "div_1000_31");
      do_div(10'd1023, 5'd1,  "div_1023_1");
      do_div(10'd7,    5'd9,  "div_7_9");
      do_div(10'd0,    5'd31, "div_0_31");
      do_div(10'd1023, 5'd31, "div_1023_31");
   endtask

   task automatic test_div_zero();
      do_div(10'd500, 5'd0,  "div_500_0");
      do_div(10'd100, 5'd7,  "div_after_zero");
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   ndone = 0;
      int   k_first = -1;
      int   k_second = -1;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL hold_load extra_done: got done at cycle %0d expected none", k);
            end else begin
               e = sb.pop_front();
               if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
                  n_fail++;
                  $display("FAIL hold_load result: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                           quotient, remainder, div_zero, e.q, e.r, e.dz);
               end
               prev_q = e.q;
               prev_r = e.r;
            end
            if (ndone == 0) k_first = k;
            else k_second = k;
            ndone++;
         end
         if (k == 12) begin
            n_tests++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL hold_load idle_gap: got busy=%b expected 0", busy);
            end
         end
         if (k == 0)  sb.push_back(model(10'd1000, 5'd31));
         if (k == 12) sb.push_back(model(10'd964, 5'd31));
         load     = (k < 15);
         dividend = 10'(1000 - 3 * k);
         divisor  = 5'd31;
      end
      load = 1'b0;
      n_tests++;
      if (ndone != 2 || k_first != 11 || k_second != 23) begin
         n_fail++;
         $display("FAIL hold_load pulses: got %0d at %0d,%0d expected 2 at 11,23", ndone, k_first, k_second);
      end
      sb.delete();
   endtask

   task automatic test_reset_abort();
      int seen = 0;
      @(negedge clk);
      dividend = 10'd1000;
      divisor  = 5'd31;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      n_tests++;
      if (quotient !== 10'd0 || remainder !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort immediate: got q=%0d r=%0d busy=%b done=%b dz=%b expected all zero",
                  quotient, remainder, busy, done, div_zero);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL reset_abort activity: got %0d busy/done cycles expected 0", seen);
      end
      prev_q = '0;
      prev_r = '0;
      do_div(10'd100, 5'd7, "div_100_7_after_reset");
   endtask

   task automatic test_random();
      logic [9:0] a;
      logic [4:0] b;
      for (int i = 0; i < 100; i++) begin
         a = 10'($urandom_range(0, 1023));
         b = 5'($urandom_range(0, 31));
         do_div(a, b, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
